ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 181 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code decoder. It tracks the held state of a table of keys and
// queues every decoded make/break event in a small FIFO.
module ps2_key_tracker #(
   parameter int                     NUM_KEYS   = 8,
   parameter logic [9*NUM_KEYS-1:0]  KEY_CODES  = '0,
   parameter int                     FIFO_DEPTH = 4
) (
   input  logic                 inclock,
   input  logic                 resetn,
   input  logic                 scan_valid,
   input  logic [7:0]           scan_data,
   input  logic                 clear_keys,
   output logic [NUM_KEYS-1:0]  key_down,
   output logic [NUM_KEYS-1:0]  key_press,
   output logic [NUM_KEYS-1:0]  key_release,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [9:0]           evt_data,
   output logic                 evt_overflow,
   output logic [7:0]           last_data_received
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

   state_t                state_q, state_d;
   logic [2:0]            skip_q, skip_d;
   logic [NUM_KEYS-1:0]   key_down_q, key_down_d;
   logic [NUM_KEYS-1:0]   press_q, press_d;
   logic [NUM_KEYS-1:0]   release_q, release_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            last_q;
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic [9:0]            mem_q [FIFO_DEPTH];

   logic                  done, done_rel, done_ext, typematic;
   logic [NUM_KEYS-1:0]   match;
   logic                  full, empty, pop, push_req, push;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      skip_d   = skip_q;
      done     = 1'b0;
      done_rel = 1'b0;
      done_ext = 1'b0;
      if (clear_keys) begin
         state_d = S_IDLE;
         skip_d  = 3'd0;
      end else if (scan_valid) begin
         case (state_q)
            S_IDLE: begin
               case (scan_data)
                  8'hE0: state_d = S_EXT;
                  8'hF0: state_d = S_BRK;
                  8'hE1: begin
                     state_d = S_SKIP;
                     skip_d  = 3'd7;
                  end
                  8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF: state_d = S_IDLE;
                  default: done = 1'b1;
               endcase
            end
            S_EXT: begin
               if (scan_data == 8'hF0)      state_d = S_EXT_BRK;
               else if (scan_data != 8'hE0) begin
                  done     = 1'b1;
                  done_ext = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_BRK: begin
               if (scan_data == 8'hE0)      state_d = S_EXT;
               else if (scan_data != 8'hF0) begin
                  done     = 1'b1;
                  done_rel = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (scan_data != 8'hF0 && scan_data != 8'hE0) begin
                  done     = 1'b1;
                  done_rel = 1'b1;
                  done_ext = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) begin
                  skip_d  = 3'd0;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++)
         match[i] = (KEY_CODES[9*i +: 9] == {done_ext, scan_data});
   end

   // A make of an already-held mapped key is typematic repeat: no pulse and no event.
   always_comb begin
      key_down_d = key_down_q;
      press_d    = '0;
      release_d  = '0;
      typematic  = 1'b0;
      if (clear_keys) begin
         key_down_d = '0;
      end else if (done) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i]) begin
               if (!done_rel) begin
                  if (key_down_q[i]) typematic = 1'b1;
                  else               press_d[i] = 1'b1;
                  key_down_d[i] = 1'b1;
               end else begin
                  release_d[i]  = key_down_q[i];
                  key_down_d[i] = 1'b0;
               end
            end
         end
      end
   end

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop      = !empty && evt_ready;
   assign push_req = done && !typematic;
   assign push     = push_req && (!full || pop);

   always_comb begin
      overflow_d = overflow_q;
      if (clear_keys)                   overflow_d = 1'b0;
      else if (push_req && full && !pop) overflow_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         skip_q     <= 3'd0;
         key_down_q <= '0;
         press_q    <= '0;
         release_q  <= '0;
         overflow_q <= 1'b0;
         last_q     <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         key_down_q <= key_down_d;
         press_q    <= press_d;
         release_q  <= release_d;
         overflow_q <= overflow_d;
         if (scan_valid) last_q <= scan_data;
         if (push)       wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // NOTE: FIFO storage has no reset; emptiness comes from the pointers and evt_data is masked when empty.
   always_ff @(posedge inclock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {done_rel, done_ext, scan_data};
   end

   assign key_down           = key_down_q;
   assign key_press          = press_q;
   assign key_release        = release_q;
   assign evt_valid          = !empty;
   assign evt_data           = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
   assign evt_overflow       = overflow_q;
   assign last_data_received = last_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: four mapped keys, four-entry event FIFO.
module tb_ps2_key_tracker;

   logic        inclock = 1'b0;
   logic        resetn = 1'b0;
   logic        scan_valid = 1'b0;
   logic [7:0]  scan_data = 8'h00;
   logic        clear_keys = 1'b0;
   logic        evt_ready = 1'b0;
   logic [3:0]  key_down, key_press, key_release;
   logic        evt_valid, evt_overflow;
   logic [9:0]  evt_data;
   logic [7:0]  last_data_received;

   int vectors = 0;
   int miscompares = 0;

   ps2_key_tracker #(
      .NUM_KEYS   (4),
      .KEY_CODES  ({9'h16B, 9'h029, 9'h023, 9'h01C}),
      .FIFO_DEPTH (4)
   ) dut (
      .inclock            (inclock),
      .resetn             (resetn),
      .scan_valid         (scan_valid),
      .scan_data          (scan_data),
      .clear_keys         (clear_keys),
      .key_down           (key_down),
      .key_press          (key_press),
      .key_release        (key_release),
      .evt_valid          (evt_valid),
      .evt_ready          (evt_ready),
      .evt_data           (evt_data),
      .evt_overflow       (evt_overflow),
      .last_data_received (last_data_received)
   );

   always #5 inclock = ~inclock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Byte is sampled on the posedge inside this task; results are visible on return.
   task automatic send(input logic [7:0] b);
      @(negedge inclock);
      scan_valid = 1'b1;
      scan_data  = b;
      @(negedge inclock);
      scan_valid = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [9:0] exp);
      check({tag, "_valid"}, evt_valid, 1);
      check({tag, "_data"}, evt_data, exp);
      @(negedge inclock);
      evt_ready = 1'b1;
      @(negedge inclock);
      evt_ready = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge inclock);
      check("rst_key_down", key_down, 0);
      check("rst_press", key_press, 0);
      check("rst_release", key_release, 0);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_data", evt_data, 0);
      check("rst_overflow", evt_overflow, 0);
      check("rst_last", last_data_received, 0);
      resetn = 1'b1;

      // make, typematic make, break of key 0
      send(8'h1C);
      check("mk1c_down", key_down, 4'b0001);
      check("mk1c_press", key_press, 4'b0001);
      check("mk1c_evt", evt_data, 10'h01C);
      @(negedge inclock);
      check("mk1c_press_width", key_press, 0);
      send(8'h1C);
      check("typ1c_down", key_down, 4'b0001);
      check("typ1c_press", key_press, 0);
      send(8'hF0);
      check("f0_down", key_down, 4'b0001);
      check("f0_release", key_release, 0);
      send(8'h1C);
      check("brk1c_down", key_down, 0);
      check("brk1c_release", key_release, 4'b0001);
      check("brk1c_last", last_data_received, 8'h1C);
      pop_expect("q1c_a", 10'h01C);
      pop_expect("q1c_b", 10'h21C);
      check("q1c_empty", evt_valid, 0);
      check("q1c_empty_data", evt_data, 0);

      // extended key 3
      send(8'hE0);
      check("e0_noevt", evt_valid, 0);
      send(8'h6B);
      check("mk6b_down", key_down, 4'b1000);
      check("mk6b_press", key_press, 4'b1000);
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      check("brk6b_down", key_down, 0);
      check("brk6b_release", key_release, 4'b1000);
      send(8'h6B);
      check("plain6b_down", key_down, 0);
      check("plain6b_press", key_press, 0);
      pop_expect("q6b_a", 10'h16B);
      pop_expect("q6b_b", 10'h36B);
      pop_expect("q6b_c", 10'h06B);
      check("q6b_empty", evt_valid, 0);

      // overflow on full FIFO
      for (int i = 0; i < 6; i++) begin
         send(8'h15);
         if (i == 3) check("ovf_after4", evt_overflow, 0);
      end
      check("ovf_set", evt_overflow, 1);
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop", 10'h015);
      check("ovf_empty", evt_valid, 0);
      @(negedge inclock);
      evt_ready = 1'b1;
      @(negedge inclock);
      evt_ready = 1'b0;
      check("pop_empty_valid", evt_valid, 0);
      check("pop_empty_data", evt_data, 0);
      check("ovf_sticky", evt_overflow, 1);
      @(negedge inclock);
      clear_keys = 1'b1;
      @(negedge inclock);
      clear_keys = 1'b0;
      check("ovf_cleared", evt_overflow, 0);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) send(8'h15);
      @(negedge inclock);
      scan_valid = 1'b1;
      scan_data  = 8'h15;
      evt_ready  = 1'b1;
      @(negedge inclock);
      scan_valid = 1'b0;
      evt_ready  = 1'b0;
      check("pushpop_ovf", evt_overflow, 0);
      for (int i = 0; i < 4; i++) pop_expect("pushpop_pop", 10'h015);
      check("pushpop_empty", evt_valid, 0);

      // E1 pause sequence is skipped
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      check("skip_noevt", evt_valid, 0);
      check("skip_down", key_down, 0);
      send(8'h29);
      check("mk29_down", key_down, 4'b0100);
      check("mk29_press", key_press, 4'b0100);
      pop_expect("q29", 10'h029);

      // async reset mid-sequence
      send(8'hE0);
      send(8'hF0);
      #2 resetn = 1'b0;
      #1;
      check("arst_down", key_down, 0);
      check("arst_last", last_data_received, 0);
      check("arst_valid", evt_valid, 0);
      @(negedge inclock);
      resetn = 1'b1;
      send(8'h23);
      check("mk23_down", key_down, 4'b0010);
      check("mk23_last", last_data_received, 8'h23);
      pop_expect("q23", 10'h023);
      send(8'hFA);
      check("ign_fa_valid", evt_valid, 0);
      check("ign_fa_last", last_data_received, 8'hFA);
      send(8'hF0);
      send(8'hE0);
      send(8'h6B);
      check("brk_e0_down", key_down, 4'b1010);
      check("brk_e0_press", key_press, 4'b1000);

      // clear_keys with held keys and a same-cycle byte
      send(8'h1C);
      send(8'h29);
      check("hold_all", key_down, 4'b1111);
      send(8'hF0);
      @(negedge inclock);
      clear_keys = 1'b1;
      scan_valid = 1'b1;
      scan_data  = 8'h23;
      @(negedge inclock);
      clear_keys = 1'b0;
      scan_valid = 1'b0;
      check("clr_down", key_down, 0);
      check("clr_release", key_release, 0);
      pop_expect("clr_q_a", 10'h16B);
      pop_expect("clr_q_b", 10'h01C);
      pop_expect("clr_q_c", 10'h029);
      check("clr_q_empty", evt_valid, 0);
      send(8'h23);
      check("clr_idle_down", key_down, 4'b0010);
      check("clr_idle_press", key_press, 4'b0010);
      pop_expect("clr_q_d", 10'h023);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
